// File: rtl/lighting_pkg.sv
// Shared lighting-interface definitions.
//   NUM_LIGHTS  : number of physical lamp lines
//   COUNT_W     : width of the active-light count
//   lamp_vec_t  : one bit per lamp, lamp 0 in the LSB
//   light_cnt_t : decoded active-light count
//   fb_state_t  : feedback-decoder settle FSM states
package lighting_pkg;

  localparam int NUM_LIGHTS = 16;
  localparam int COUNT_W    = 4;

  typedef logic [NUM_LIGHTS-1:0] lamp_vec_t;
  typedef logic [COUNT_W-1:0]    light_cnt_t;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } fb_state_t;

endpackage

// File: rtl/lamp_therm_check.sv
// Combinational thermometer-code checker for the lamp feedback pattern.
//   i_pattern : settled lamp pattern
//   o_legal   : pattern is a valid thermometer code the controller can produce
//   o_count   : active-light count (0..14 lamps -> 0..14, all 16 lamps -> 15)
import lighting_pkg::*;

module lamp_therm_check (
  input  lamp_vec_t  i_pattern,
  output logic       o_legal,
  output light_cnt_t o_count
);

  localparam int ONES_W = $clog2(NUM_LIGHTS + 1);

  logic [ONES_W-1:0]   w_ones;
  logic [NUM_LIGHTS:0] w_ext;
  logic [NUM_LIGHTS:0] w_inc;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      w_ones = w_ones + ONES_W'(i_pattern[i]);
    end
  end

  // A thermometer code plus one is a single power of two, so it shares no
  // bits with the original. The extra bit keeps 0xFFFF from wrapping to 0.
  assign w_ext = {1'b0, i_pattern};
  assign w_inc = w_ext + (NUM_LIGHTS + 1)'(1);

  // 15 lamps is never driven (count 15 lights all 16), so 0x7FFF is a fault.
  assign o_legal = ((w_ext & w_inc) == '0) && (w_ones != ONES_W'(15));
  assign o_count = (w_ones == ONES_W'(16)) ? light_cnt_t'(15) : w_ones[COUNT_W-1:0];

endmodule

// File: rtl/lamp_feedback_decoder.sv
// Lamp feedback return path: synchronises and debounces the 16 lamp-feedback
// lines, checks the thermometer code and hands each new settled count to the
// home controller over valid/ready.
//   clk, rst_n        : system clock, async active-low reset
//   i_lamp_fb         : raw lamp feedback, asynchronous to clk
//   i_out_ready       : consumer takes o_out_count this cycle
//   i_err_clr         : clears o_err_sticky and o_overrun
//   o_out_valid       : o_out_count holds an undelivered count
//   o_out_count       : decoded count for the consumer
//   o_active_lights   : last legal decoded count
//   o_err_sticky      : an illegal pattern settled since last clear
//   o_err_pattern     : most recent illegal settled pattern
//   o_overrun         : an undelivered count was overwritten
//
// state    | meaning
// S_IDLE   | synced lines match the accepted pattern
// S_SETTLE | counting consecutive identical samples of a candidate pattern
import lighting_pkg::*;

module lamp_feedback_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  lamp_vec_t  i_lamp_fb,
  input  logic       i_out_ready,
  input  logic       i_err_clr,
  output logic       o_out_valid,
  output light_cnt_t o_out_count,
  output light_cnt_t o_active_lights,
  output logic       o_err_sticky,
  output lamp_vec_t  o_err_pattern,
  output logic       o_overrun
);

  localparam int                STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  lamp_vec_t         r_sync1;
  lamp_vec_t         r_sync2;
  lamp_vec_t         r_accepted;
  lamp_vec_t         r_cand;
  logic [STAB_W-1:0] r_stab;
  fb_state_t         r_state;

  logic       w_accept;
  logic       w_event;
  logic       w_legal;
  light_cnt_t w_count;
  logic       w_load;
  logic       w_bad;

  lamp_therm_check u_check (
    .i_pattern (r_cand),
    .o_legal   (w_legal),
    .o_count   (w_count)
  );

  // r_cand has been seen STABLE_CYCLES times in a row; a settle that lands
  // back on the accepted pattern was a glitch and produces nothing.
  assign w_accept = (r_state == S_SETTLE) && (r_stab == STAB_MAX);
  assign w_event  = w_accept && (r_cand != r_accepted);
  assign w_load   = w_event && w_legal;
  assign w_bad    = w_event && !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_lamp_fb;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_accepted <= '0;
      r_cand     <= '0;
      r_stab     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_sync2 != r_accepted) begin
            r_state <= S_SETTLE;
            r_cand  <= r_sync2;
            r_stab  <= STAB_W'(1);
          end
        end
        S_SETTLE: begin
          if (w_accept) begin
            r_state    <= S_IDLE;
            r_accepted <= r_cand;
          end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_stab <= STAB_W'(1);
          end else begin
            r_stab <= r_stab + STAB_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid     <= 1'b0;
      o_out_count     <= '0;
      o_active_lights <= '0;
      o_err_sticky    <= 1'b0;
      o_err_pattern   <= '0;
      o_overrun       <= 1'b0;
    end else begin
      if (w_load) begin
        o_out_valid     <= 1'b1;
        o_out_count     <= w_count;
        o_active_lights <= w_count;
      end else if (o_out_valid && i_out_ready) begin
        o_out_valid <= 1'b0;
      end

      // Setting beats clearing so an event in the err_clr cycle is not lost.
      if (w_load && o_out_valid && !i_out_ready) begin
        o_overrun <= 1'b1;
      end else if (i_err_clr) begin
        o_overrun <= 1'b0;
      end

      if (w_bad) begin
        o_err_sticky  <= 1'b1;
        o_err_pattern <= r_cand;
      end else if (i_err_clr) begin
        o_err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lamp_feedback_decoder.sv
module tb_lamp_feedback_decoder;

  localparam int SC = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] lamp_fb;
  logic        out_ready;
  logic        err_clr;
  logic        out_valid;
  logic [3:0]  out_count;
  logic [3:0]  active_lights;
  logic        err_sticky;
  logic [15:0] err_pattern;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  lamp_feedback_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_lamp_fb       (lamp_fb),
    .i_out_ready     (out_ready),
    .i_err_clr       (err_clr),
    .o_out_valid     (out_valid),
    .o_out_count     (out_count),
    .o_active_lights (active_lights),
    .o_err_sticky    (err_sticky),
    .o_err_pattern   (err_pattern),
    .o_overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sample history drives a "seen N times in a row"
  // filter; the decode is done by counting ones and matching 2^n-1.
  logic [15:0] m_sync1, m_s, m_acc, m_cand;
  bit          m_settling;
  int          m_run;
  logic        m_valid, m_err, m_ovr;
  logic [3:0]  m_count, m_active;
  logic [15:0] m_errpat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 = '0; m_s = '0; m_acc = '0; m_cand = '0;
      m_settling = 0; m_run = 0;
      m_valid = 0; m_err = 0; m_ovr = 0;
      m_count = '0; m_active = '0; m_errpat = '0;
    end else begin
      bit          ev;
      bit          legal;
      bit          set_ovr;
      bit          set_err;
      int          ones;
      logic [15:0] p;
      logic [3:0]  c;
      ev = 0;
      p = m_cand;
      if (m_settling) begin
        if (m_run == SC) begin
          m_settling = 0;
          ev = (m_cand != m_acc);
          m_acc = m_cand;
        end else if (m_s != m_cand) begin
          m_cand = m_s;
          m_run = 1;
        end else begin
          m_run++;
        end
      end else if (m_s != m_acc) begin
        m_settling = 1;
        m_cand = m_s;
        m_run = 1;
      end
      ones = $countones(p);
      legal = (32'(p) == ((32'd1 << ones) - 32'd1)) && (ones != 15);
      c = (ones == 16) ? 4'd15 : 4'(ones);
      set_ovr = ev && legal && m_valid && !out_ready;
      set_err = ev && !legal;
      if (ev && legal) begin
        m_valid = 1; m_count = c; m_active = c;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (set_ovr) m_ovr = 1; else if (err_clr) m_ovr = 0;
      if (set_err) begin m_err = 1; m_errpat = p; end
      else if (err_clr) m_err = 0;
      m_s = m_sync1;
      m_sync1 = lamp_fb;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_count", 32'(out_count), 32'(m_count));
    chk("active_lights", 32'(active_lights), 32'(m_active));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    chk("err_pattern", 32'(err_pattern), 32'(m_errpat));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (out_valid && out_ready) n_xfer++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  int x0;

  initial begin
    rst_n = 1'b0; lamp_fb = 16'h00FF; out_ready = 1'b1; err_clr = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_active", 32'(active_lights), 32'd0);
    rst_n = 1'b1;
    cyc(SC + 2);
    chk("lat_before", 32'(out_valid), 32'd0);
    cyc(1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_count8", 32'(out_count), 32'd8);
    cyc(1);
    chk("pulse_end", 32'(out_valid), 32'd0);

    lamp_fb = 16'h0000;
    cyc(10);
    chk("zero_active", 32'(active_lights), 32'd0);
    lamp_fb = 16'h003F;
    cyc(SC + 2);
    chk("step_before", 32'(out_valid), 32'd0);
    cyc(1);
    chk("step_valid", 32'(out_valid), 32'd1);
    chk("step_count6", 32'(out_count), 32'd6);
    chk("step_active6", 32'(active_lights), 32'd6);
    cyc(1);
    chk("step_pulse_end", 32'(out_valid), 32'd0);

    lamp_fb = 16'hFFFF;
    cyc(10);
    chk("full_active15", 32'(active_lights), 32'd15);

    x0 = n_xfer;
    lamp_fb = 16'h7FFF;
    cyc(10);
    chk("bad15_no_xfer", 32'(n_xfer - x0), 32'd0);
    chk("bad15_err", 32'(err_sticky), 32'd1);
    chk("bad15_pat", 32'(err_pattern), 32'h7FFF);
    chk("bad15_active", 32'(active_lights), 32'd15);
    clr_pulse();
    chk("clr_err", 32'(err_sticky), 32'd0);
    chk("clr_pat_kept", 32'(err_pattern), 32'h7FFF);

    lamp_fb = 16'h00F7;
    cyc(10);
    chk("bubble_err", 32'(err_sticky), 32'd1);
    chk("bubble_pat", 32'(err_pattern), 32'h00F7);
    chk("bubble_active", 32'(active_lights), 32'd15);
    clr_pulse();

    lamp_fb = 16'h0001;
    cyc(10);
    chk("one_active", 32'(active_lights), 32'd1);
    x0 = n_xfer;
    lamp_fb = 16'h0003;
    cyc(SC - 1);
    lamp_fb = 16'h0001;
    cyc(12);
    chk("glitch_no_xfer", 32'(n_xfer - x0), 32'd0);
    chk("glitch_no_err", 32'(err_sticky), 32'd0);
    chk("glitch_active", 32'(active_lights), 32'd1);

    lamp_fb = 16'h0000;
    cyc(10);
    out_ready = 1'b0;
    lamp_fb = 16'h0001;
    cyc(10);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_count1", 32'(out_count), 32'd1);
    cyc(3);
    chk("hold_stable", 32'(out_count), 32'd1);
    chk("hold_no_ovr", 32'(overrun), 32'd0);
    lamp_fb = 16'h0007;
    cyc(10);
    chk("ovr_count3", 32'(out_count), 32'd3);
    chk("ovr_flag", 32'(overrun), 32'd1);
    x0 = n_xfer;
    out_ready = 1'b1;
    cyc(3);
    chk("ovr_one_xfer", 32'(n_xfer - x0), 32'd1);
    chk("ovr_valid_low", 32'(out_valid), 32'd0);
    clr_pulse();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    lamp_fb = 16'h000F;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_active", 32'(active_lights), 32'd0);
    rst_n = 1'b1;
    cyc(SC + 3);
    chk("redecode_valid", 32'(out_valid), 32'd1);
    chk("redecode_count4", 32'(out_count), 32'd4);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
